// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, host FSM encoding, UART byte width,
// and the legal-opcode check used by both the UART driver and the alu bench.
package alu_pkg;

  localparam int NB_BYTE = 8;
  localparam int OP_W    = 6;

  localparam logic [OP_W-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction

endpackage

// File: rtl/alu_uart_interface.sv
// UART <-> alu host driver: 3-byte frame (A, B, OP) in, 1 result byte out.
// Define ALU_UART_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES.
import alu_pkg::*;

module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_BYTE        = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_tx_done,
  input  logic signed [NB_DATA-1:0] i_alu_result,
  output logic signed [NB_DATA-1:0] o_datoA,
  output logic signed [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]          o_operation,
  output logic [NB_BYTE-1:0]        o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy,
  output logic                      o_err
);

  if (NB_DATA < 1 || NB_DATA > 8 || NB_DATA > NB_BYTE) begin : g_bad_nb_data
    $error("alu_uart_interface: NB_DATA out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("alu_uart_interface: TIMEOUT_CYCLES too small");
  end

  state_e state_q, state_d;

  logic signed [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic signed [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]          op_q, op_d;
  logic [NB_BYTE-1:0]        tx_data_q, tx_data_d;
  logic                      err_q, err_d;

  logic                      op_legal;
  logic                      timeout_exp;
  logic signed [NB_BYTE-1:0] alu_ext;

  assign op_legal = is_legal_op(OP_W'(i_rx_data[NB_OP-1:0]));
  assign alu_ext  = NB_BYTE'(i_alu_result);

`ifdef ALU_UART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_wait;

  // Counts only while a frame is partially received; any byte restarts it.
  assign to_wait     = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
  assign timeout_exp = to_wait && !i_rx_valid &&
                       (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (to_wait && !i_rx_valid && !timeout_exp) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_exp = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) state_d = ST_GET_B;
      end
      ST_GET_B: begin
        if (i_rx_valid)       state_d = ST_GET_OP;
        else if (timeout_exp) state_d = ST_IDLE;
      end
      ST_GET_OP: begin
        if (i_rx_valid)       state_d = op_legal ? ST_EXEC : ST_IDLE;
        else if (timeout_exp) state_d = ST_IDLE;
      end
      ST_EXEC:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath updates; operands and opcode persist across frames.
  always_comb begin
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) dato_a_d = i_rx_data[NB_DATA-1:0];
      end
      ST_GET_B: begin
        if (i_rx_valid)       dato_b_d = i_rx_data[NB_DATA-1:0];
        else if (timeout_exp) err_d = 1'b1;
      end
      ST_GET_OP: begin
        if (i_rx_valid) begin
          if (op_legal) op_d = i_rx_data[NB_OP-1:0];
          else          err_d = 1'b1;
        end else if (timeout_exp) begin
          err_d = 1'b1;
        end
      end
      ST_EXEC:  tx_data_d = alu_ext;
      default: ;
    endcase
  end

  always_comb begin
    o_datoA     = dato_a_q;
    o_datoB     = dato_b_q;
    o_operation = op_q;
    o_tx_data   = tx_data_q;
    o_tx_start  = (state_q == ST_SEND);
    o_busy      = (state_q != ST_IDLE);
    o_err       = err_q;
  end

endmodule
